// File: rtl/seg_pkg.sv
// Seven-segment glyph constants and the pattern-to-hex decoder shared by the reader.
// Purely combinational helpers; no latency of their own.
// No flow control: decode is a pure function of a 7-bit pattern.
package seg_pkg;

  // Patterns are {A,B,C,D,E,F,G}, A = MSB, bit = 1 means the segment is lit.
  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_0 = 7'h7E;
  localparam logic [6:0] GLYPH_1 = 7'h30;
  localparam logic [6:0] GLYPH_2 = 7'h6D;
  localparam logic [6:0] GLYPH_3 = 7'h79;
  localparam logic [6:0] GLYPH_4 = 7'h33;
  localparam logic [6:0] GLYPH_5 = 7'h5B;
  localparam logic [6:0] GLYPH_6 = 7'h5F;
  localparam logic [6:0] GLYPH_7 = 7'h70;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h7B;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h1F;
  localparam logic [6:0] GLYPH_C = 7'h4E;
  localparam logic [6:0] GLYPH_D = 7'h3D;
  localparam logic [6:0] GLYPH_E = 7'h4F;
  localparam logic [6:0] GLYPH_F = 7'h47;

  typedef enum logic [1:0] {
    KIND_BLANK = 2'd0,
    KIND_VALID = 2'd1,
    KIND_ERR   = 2'd2
  } seg_kind_t;

  // Returns {kind[1:0], value[3:0]}; value is 0 for blank/err patterns.
  function automatic logic [5:0] seg_decode(input logic [6:0] i_pat);
    case (i_pat)
      GLYPH_0:     return {KIND_VALID, 4'h0};
      GLYPH_1:     return {KIND_VALID, 4'h1};
      GLYPH_2:     return {KIND_VALID, 4'h2};
      GLYPH_3:     return {KIND_VALID, 4'h3};
      GLYPH_4:     return {KIND_VALID, 4'h4};
      GLYPH_5:     return {KIND_VALID, 4'h5};
      GLYPH_6:     return {KIND_VALID, 4'h6};
      GLYPH_7:     return {KIND_VALID, 4'h7};
      GLYPH_8:     return {KIND_VALID, 4'h8};
      GLYPH_9:     return {KIND_VALID, 4'h9};
      GLYPH_A:     return {KIND_VALID, 4'hA};
      GLYPH_B:     return {KIND_VALID, 4'hB};
      GLYPH_C:     return {KIND_VALID, 4'hC};
      GLYPH_D:     return {KIND_VALID, 4'hD};
      GLYPH_E:     return {KIND_VALID, 4'hE};
      GLYPH_F:     return {KIND_VALID, 4'hF};
      GLYPH_BLANK: return {KIND_BLANK, 4'h0};
      default:     return {KIND_ERR, 4'h0};
    endcase
  endfunction

endpackage

// File: rtl/seg_digit_filter.sv
// One digit: 2-flop pin synchroniser, stability filter, accepted-pattern register and decode.
// Outputs change STABLE_CYCLES+2 edges after the first sampling edge of a held pin change.
// No backpressure: pins are sampled every cycle; o_change is a single-cycle pulse.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_pins raw segment pins {A..G};
//        o_digit last legal hex value; o_valid/o_blank/o_err one-hot pattern class;
//        o_change pulses when the accepted pattern differs from the previous one.
module seg_digit_filter
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 250000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_pins,
  output logic [3:0] o_digit,
  output logic       o_valid,
  output logic       o_blank,
  output logic       o_err,
  output logic       o_change
);

  // Pin level of an unlit segment; also the normalisation mask.
  localparam logic [6:0]  UNLIT      = {7{SEG_ACTIVE_LOW}};
  localparam logic [19:0] STABLE_MAX = 20'(STABLE_CYCLES);

  logic [6:0]  r_sync1, r_sync2;
  logic [6:0]  r_cand, r_acc;
  logic [19:0] r_cnt;
  logic [6:0]  w_pattern;
  logic        w_accept;
  logic [5:0]  w_dec;
  seg_kind_t   w_kind;

  // Synchroniser resets to the unlit level so the post-reset pattern is blank.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= UNLIT;
      r_sync2 <= UNLIT;
    end else begin
      r_sync1 <= i_pins;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pattern = r_sync2 ^ UNLIT;

  // Acceptance fires on the single STABLE_MAX-1 -> STABLE_MAX step; saturation
  // keeps it from re-firing while the pattern keeps holding.
  assign w_accept = (w_pattern == r_cand) && (r_cnt == STABLE_MAX - 20'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand <= GLYPH_BLANK;
      r_cnt  <= 20'd0;
    end else if (w_pattern != r_cand) begin
      r_cand <= w_pattern;
      r_cnt  <= 20'd0;
    end else if (r_cnt < STABLE_MAX) begin
      r_cnt  <= r_cnt + 20'd1;
    end
  end

  assign w_dec  = seg_decode(r_cand);
  assign w_kind = seg_kind_t'(w_dec[5:4]);

  // A glitch that settles back onto the accepted glyph is re-accepted silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= GLYPH_BLANK;
      o_digit  <= 4'h0;
      o_valid  <= 1'b0;
      o_blank  <= 1'b1;
      o_err    <= 1'b0;
      o_change <= 1'b0;
    end else begin
      o_change <= 1'b0;
      if (w_accept && (r_cand != r_acc)) begin
        r_acc    <= r_cand;
        o_change <= 1'b1;
        o_valid  <= (w_kind == KIND_VALID);
        o_blank  <= (w_kind == KIND_BLANK);
        o_err    <= (w_kind == KIND_ERR);
        // digit keeps the last legal value across blank/illegal patterns
        if (w_kind == KIND_VALID) begin
          o_digit <= w_dec[3:0];
        end
      end
    end
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Reads a two-digit seven-segment bus back into hex nibbles with per-digit debounce.
// update strobes STABLE_CYCLES+3 edges after the first sampling edge of a held change.
// No backpressure: update is a one-cycle strobe; change_count wraps at 16 bits.
//
// Ports: clock/reset_n clock and async active-low reset; seg1_pins/seg2_pins raw pins {A..G};
//        digitN/validN/blankN/errN per-digit decode results; update change strobe;
//        change_count number of update strobes since reset.
module seven_seg_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 250000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  seg1_pins,
  input  logic [6:0]  seg2_pins,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic        valid1,
  output logic        valid2,
  output logic        blank1,
  output logic        blank2,
  output logic        err1,
  output logic        err2,
  output logic        update,
  output logic [15:0] change_count
);

  logic w_chg1, w_chg2, w_any_chg;

  seg_digit_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_digit1 (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_pins  (seg1_pins),
    .o_digit (digit1),
    .o_valid (valid1),
    .o_blank (blank1),
    .o_err   (err1),
    .o_change(w_chg1)
  );

  seg_digit_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_digit2 (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_pins  (seg2_pins),
    .o_digit (digit2),
    .o_valid (valid2),
    .o_blank (blank2),
    .o_err   (err2),
    .o_change(w_chg2)
  );

  // Simultaneous changes on both digits merge into a single strobe.
  assign w_any_chg = w_chg1 | w_chg2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      update       <= 1'b0;
      change_count <= 16'h0000;
    end else begin
      update       <= w_any_chg;
      change_count <= change_count + {15'd0, w_any_chg};
    end
  end

endmodule
